bp_updater: RTL and testbench

- Write-side controller for the branch-prediction counter cache (bp_cache). It accepts resolved-branch reports from the execute stage, reads the current 2-bit counter through the cache's second read port, and writes back the updated saturating counter.
- Fetch keeps read port 0 for prediction. bp_updater owns read port 1 (ra1/dout1/hit1) and the write port (wa/din/we).
- Cache contract: reads are combinational (address to dout/hit in the same cycle); writes take effect at the posedge where we=1.

---
 rtl/bp_updater.sv | 153 +++++++++++++++
 tb/tb_bp_updater.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_updater.sv
// Write-side controller for the branch-prediction counter cache: queues resolved
// branches, reads the 2-bit counter on read port 1 and writes back the saturated update.
module bp_updater #(
    parameter int AWIDTH   = 30,
    parameter int QDEPTH   = 2,
    parameter int SKIP_SAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [AWIDTH-1:0] res_pc,
    input  logic              res_taken,
    output logic [AWIDTH-1:0] cache_ra,
    input  logic [1:0]        cache_rdout,
    input  logic              cache_rhit,
    output logic [AWIDTH-1:0] cache_wa,
    output logic [1:0]        cache_din,
    output logic              cache_we,
    output logic              busy,
    output logic [15:0]       upd_cnt
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);
    localparam bit SKIP = (SKIP_SAT != 0);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic              taken;
    } report_t;

    state_e            state_q, state_d;
    report_t           mem_q [QDEPTH];
    report_t           mem_d [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [AWIDTH-1:0] wpc_q, wpc_d;
    logic              wtk_q, wtk_d;
    logic              hit_q, hit_d;
    logic [1:0]        ctr_q, ctr_d;
    logic [15:0]       upd_q, upd_d;

    logic       full, empty, enq, deq, we;
    logic [1:0] nc;

    // New counter: misses start weak toward the outcome, hits saturate without wrap.
    always_comb begin
        nc = 2'b00;
        if (!hit_q)
            nc = wtk_q ? 2'b10 : 2'b01;
        else if (wtk_q)
            nc = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'b01;
        else
            nc = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'b01;
    end

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wpc_d    = wpc_q;
        wtk_d    = wtk_q;
        hit_d    = hit_q;
        ctr_d    = ctr_q;
        upd_d    = upd_q;
        we       = 1'b0;
        deq      = 1'b0;

        full  = (count_q == QFULL);
        empty = (count_q == '0);
        enq   = res_valid && !full;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    deq     = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                hit_d   = cache_rhit;
                ctr_d   = cache_rdout;
                state_d = WRITE;
            end
            WRITE: begin
                we = !(SKIP && hit_q && (nc == ctr_q));
                if (we)
                    upd_d = upd_q + 16'd1;
                if (!empty) begin
                    deq     = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (deq) begin
            wpc_d    = mem_q[rd_ptr_q].pc;
            wtk_d    = mem_q[rd_ptr_q].taken;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            mem_d[wr_ptr_q] = '{pc: res_pc, taken: res_taken};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wpc_q    <= '0;
            wtk_q    <= 1'b0;
            hit_q    <= 1'b0;
            ctr_q    <= 2'b00;
            upd_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wpc_q    <= wpc_d;
            wtk_q    <= wtk_d;
            hit_q    <= hit_d;
            ctr_q    <= ctr_d;
            upd_q    <= upd_d;
        end
    end

    // Outputs derive only from registered state, so reset clears them without a clock.
    assign res_ready = (count_q != QFULL);
    assign busy      = (count_q != '0) || (state_q != IDLE);
    assign cache_ra  = wpc_q;
    assign cache_wa  = wpc_q;
    assign cache_din = (state_q == WRITE) ? nc : 2'b00;
    assign cache_we  = we;
    assign upd_cnt   = upd_q;
endmodule

// File: tb/tb_bp_updater.sv
// Bench for bp_updater: a small direct-mapped cache model serves the DUT, and an
// in-order reference model predicts every write and the update count.
module tb_bp_updater;
    localparam int AW = 30;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [AW-1:0] res_pc = '0;
    logic          res_taken = 1'b0;
    logic [AW-1:0] cache_ra, cache_wa;
    logic [1:0]    cache_rdout, cache_din;
    logic          cache_rhit, cache_we, busy;
    logic [15:0]   upd_cnt;

    bp_updater #(.AWIDTH(AW), .QDEPTH(QD), .SKIP_SAT(1)) dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_taken(res_taken),
        .cache_ra(cache_ra), .cache_rdout(cache_rdout), .cache_rhit(cache_rhit),
        .cache_wa(cache_wa), .cache_din(cache_din), .cache_we(cache_we),
        .busy(busy), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int writes_seen = 0;
    int last_we = -1;
    bit spacing_on = 0;
    bit saw_notready = 0;

    // Environment cache: index = pc[7:0], tag = upper bits.
    bit            env_v   [256];
    bit [AW-9:0]   env_tag [256];
    bit [1:0]      env_val [256];
    // Reference model's view of the cache after every accepted report.
    bit            ref_v   [256];
    bit [AW-9:0]   ref_tag [256];
    bit [1:0]      ref_val [256];

    typedef struct {
        logic [AW-1:0] pc;
        logic [1:0]    nc;
    } exp_t;
    exp_t expq[$];

    always_comb begin
        cache_rhit  = env_v[cache_ra[7:0]] && (env_tag[cache_ra[7:0]] == cache_ra[AW-1:8]);
        cache_rdout = env_val[cache_ra[7:0]];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [AW-1:0] pc);
        if (env_v[pc[7:0]] && env_tag[pc[7:0]] == pc[AW-1:8]) return int'(env_val[pc[7:0]]);
        return -1;
    endfunction

    // Reports are applied in arrival order; each write lands before the next read.
    task automatic model_accept(input logic [AW-1:0] pc, input logic tk);
        int  i, cur, nc;
        bit  hit;
        exp_t e;
        i   = int'(pc[7:0]);
        hit = ref_v[i] && ref_tag[i] == pc[AW-1:8];
        cur = int'(ref_val[i]);
        if (!hit)    nc = tk ? 2 : 1;
        else if (tk) nc = (cur + 1 > 3) ? 3 : cur + 1;
        else         nc = (cur - 1 < 0) ? 0 : cur - 1;
        if (!(hit && nc == cur)) begin
            e.pc = pc;
            e.nc = 2'(nc);
            expq.push_back(e);
            ref_v[i]   = 1'b1;
            ref_tag[i] = pc[AW-1:8];
            ref_val[i] = 2'(nc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (cache_we) begin
            env_v[cache_wa[7:0]]   <= 1'b1;
            env_tag[cache_wa[7:0]] <= cache_wa[AW-1:8];
            env_val[cache_wa[7:0]] <= cache_din;
        end
        if (reset && res_valid && res_ready) model_accept(res_pc, res_taken);
    end

    // Reset drops everything in flight: the true cache is whatever actually landed.
    always @(negedge reset) begin
        expq.delete();
        writes_seen = 0;
        last_we = -1;
        for (int i = 0; i < 256; i++) begin
            ref_v[i]   = env_v[i];
            ref_tag[i] = env_tag[i];
            ref_val[i] = env_val[i];
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("upd_cnt", upd_cnt, writes_seen & 16'hFFFF);
            if (cache_we) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: wa=%0h din=%0d expected no write", cache_wa, cache_din);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("write_wa", cache_wa, e.pc);
                    chk("write_din", cache_din, e.nc);
                end
                if (spacing_on && last_we >= 0) chk("write_spacing", cyc - last_we, 2);
                last_we = cyc;
                writes_seen++;
            end
        end
    end

    task automatic send(input logic [AW-1:0] pc, input logic tk);
        int n = 0;
        res_valid = 1'b1; res_pc = pc; res_taken = tk;
        while (!res_ready && n < 100) begin @(negedge clk); n++; end
        if (!res_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: res_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 300);
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=1 expected 0 within 300 cycles");
        end
    endtask

    localparam logic [AW-1:0] PC_A = 30'h1557_557F;
    localparam logic [AW-1:0] PC_B = 30'h3557_557F;

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we", cache_we, 0);
        chk("rst_ra", cache_ra, 0);
        chk("rst_wa", cache_wa, 0);
        chk("rst_din", cache_din, 0);
        chk("rst_upd", upd_cnt, 0);
        chk("rst_ready", res_ready, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // Cold miss: write lands on the 3rd edge after acceptance.
        send(PC_A, 1'b1);
        chk("cold_we_e0", cache_we, 0);
        chk("cold_busy", busy, 1);
        @(negedge clk);
        chk("cold_we_e1", cache_we, 0);
        @(negedge clk);
        chk("cold_we_e2", cache_we, 1);
        chk("cold_wa", cache_wa, PC_A);
        chk("cold_din", cache_din, 2);
        @(negedge clk);
        chk("cold_we_e3", cache_we, 0);
        chk("cold_upd", upd_cnt, 1);
        chk("cold_lookup", lookup(PC_A), 2);
        wait_idle();

        repeat (3) send(PC_A, 1'b1);
        wait_idle();
        chk("satup_upd", upd_cnt, 2);
        chk("satup_val", lookup(PC_A), 3);

        repeat (4) send(PC_A, 1'b0);
        wait_idle();
        chk("satdn_upd", upd_cnt, 5);
        chk("satdn_val", lookup(PC_A), 0);

        send(PC_A, 1'b1);
        send(PC_B, 1'b0);
        wait_idle();
        chk("evict_b", lookup(PC_B), 1);
        chk("evict_a", lookup(PC_A), -1);
        chk("evict_upd", upd_cnt, 7);

        // Backpressure: six back-to-back reports with valid held high.
        spacing_on = 1; last_we = -1;
        res_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            res_pc = 30'h10 + AW'(k); res_taken = k[0];
            while (!res_ready && n < 100) begin saw_notready = 1; @(negedge clk); n++; end
            @(posedge clk);
            @(negedge clk);
        end
        res_valid = 1'b0;
        wait_idle();
        spacing_on = 0;
        chk("bp_ready_dropped", saw_notready, 1);
        chk("bp_upd", upd_cnt, 13);
        chk("bp_last", lookup(30'h15), 2);

        // Random traffic over a few indices and tags to mix hits, misses and saturation.
        for (int k = 0; k < 400; k++) begin
            res_valid = ($urandom_range(0, 1) == 1);
            res_pc    = {AW'($urandom_range(0, 3)) << 8} | AW'(8'h20 + $urandom_range(0, 3));
            res_taken = $urandom_range(0, 3) != 0;
            @(negedge clk);
        end
        res_valid = 1'b0;
        wait_idle();
        chk("rand_drained", expq.size(), 0);

        // Async reset while a write is on the port.
        send(30'h40, 1'b1);
        send(30'h41, 1'b0);
        begin
            int n = 0;
            while (!cache_we && n < 20) begin @(negedge clk); n++; end
            chk("rst_reach_write", cache_we, 1);
        end
        #3 reset = 1'b0;
        #1;
        chk("arst_we", cache_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", res_ready, 1);
        chk("arst_upd", upd_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_ready", res_ready, 1);
        chk("post_upd", upd_cnt, 0);
        chk("post_nowrite", lookup(30'h40), -1);
        send(30'h40, 1'b1);
        wait_idle();
        chk("recover_val", lookup(30'h40), 2);
        chk("recover_upd", upd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
